// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch controller
package fetch_ctrl_pkg;
  typedef enum logic {IDLE, MD_BUSY} md_state_t;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] PC_STEP  = 32'd4;
endpackage

// File: rtl/fetch_ctrl_md_busy_cnt.sv
// md_busy_cnt: HI/LO occupancy FSM with down-counter
module md_busy_cnt
  import fetch_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);
  localparam int CW = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC - 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC - 1);
  md_state_t state;
  logic [CW-1:0] cnt;
  // starts while busy (including the final cycle) are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
    end else if (state == IDLE) begin
      if (md_start) begin
        state   <= MD_BUSY;
        md_busy <= 1'b1;
        cnt     <= md_is_div ? DIV_LD : MULT_LD;
      end
    end else if (cnt == '0) begin
      state   <= IDLE;
      md_busy <= 1'b0;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC select, hazard stall and mult/div occupancy tracking.
// Define FETCH_CTRL_ADEL_EN to trap misaligned taken-branch targets.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int          MULT_CYC = 5,
  parameter int          DIV_CYC  = 10,
  parameter logic [31:0] RESET_PC = fetch_ctrl_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_F,
  input  logic        hzd_stall,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        md_use_D,
  input  logic        br_taken_D,
  input  logic [31:0] br_target_D,
  output logic [31:0] NPC_F,
  output logic        stall,
  output logic        flush_E,
  output logic        md_busy,
  output logic        exc_adel
);
  md_busy_cnt #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_cnt (
    .clk(clk), .reset(reset), .md_start(md_start), .md_is_div(md_is_div), .md_busy(md_busy)
  );
  logic [31:0] seq_pc;
  assign seq_pc = PC_F + PC_STEP;
`ifdef FETCH_CTRL_ADEL_EN
  assign exc_adel = ~reset & br_taken_D & (br_target_D[1:0] != 2'b00);
  assign NPC_F = exc_adel ? EXC_VEC : br_taken_D ? br_target_D : seq_pc;
`else
  assign exc_adel = 1'b0;
  assign NPC_F = br_taken_D ? br_target_D : seq_pc;
`endif
  assign stall   = hzd_stall | (md_use_D & (md_busy | md_start));
  assign flush_E = stall;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors with a queued-expectation scoreboard
module tb_fetch_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] PC_F = 32'h3000, br_target_D = '0, NPC_F;
  logic hzd_stall = 0, md_start = 0, md_is_div = 0, md_use_D = 0, br_taken_D = 0;
  logic stall, flush_E, md_busy, exc_adel;
  int checks = 0, errors = 0;

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        st, bz, ex;
  } exp_t;
  exp_t q[$];

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .PC_F(PC_F), .hzd_stall(hzd_stall), .md_start(md_start),
    .md_is_div(md_is_div), .md_use_D(md_use_D), .br_taken_D(br_taken_D),
    .br_target_D(br_target_D), .NPC_F(NPC_F), .stall(stall), .flush_E(flush_E),
    .md_busy(md_busy), .exc_adel(exc_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.name, " npc"}, NPC_F, e.npc);
      chk({e.name, " stall"}, {31'd0, stall}, {31'd0, e.st});
      chk({e.name, " flush"}, {31'd0, flush_E}, {31'd0, e.st});
      chk({e.name, " busy"}, {31'd0, md_busy}, {31'd0, e.bz});
      chk({e.name, " adel"}, {31'd0, exc_adel}, {31'd0, e.ex});
    end
  end

  task automatic step(input string n, input logic rst, input logic [31:0] pc, input logic hz,
                      input logic ms, input logic dv, input logic mu, input logic bt,
                      input logic [31:0] tgt, input logic [31:0] enpc, input logic est,
                      input logic ebz, input logic eex);
    @(posedge clk);
    #1;
    reset = rst; PC_F = pc; hzd_stall = hz; md_start = ms; md_is_div = dv;
    md_use_D = mu; br_taken_D = bt; br_target_D = tgt;
    q.push_back(exp_t'{n, enpc, est, ebz, eex});
  endtask

  task automatic cyc(input string n, input logic rst, input logic ms, input logic dv,
                     input logic mu, input logic ebz, input logic est);
    step(n, rst, 32'h3000, 0, ms, dv, mu, 0, 32'h0, 32'h3004, est, ebz, 0);
  endtask

  initial begin
    cyc("reset", 1, 0, 0, 0, 0, 0);
    step("reset_hz", 1, 32'h3000, 1, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0);
    step("seq", 0, 32'h3000, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0);
    cyc("mult_c0", 0, 1, 0, 1, 0, 1);
    for (int i = 1; i <= 5; i++) cyc($sformatf("mult_c%0d", i), 0, 0, 0, 1, 1, 1);
    cyc("mult_c6", 0, 0, 0, 1, 0, 0);
    cyc("div_c0", 0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cyc($sformatf("div_c%0d", i), 0, 0, 0, 0, 1, 0);
    cyc("div_c11", 0, 0, 0, 0, 0, 0);
    cyc("ill_c0", 0, 1, 0, 0, 0, 0);
    cyc("ill_c1", 0, 0, 0, 0, 1, 0);
    cyc("ill_c2", 0, 1, 1, 0, 1, 0);
    for (int i = 3; i <= 5; i++) cyc($sformatf("ill_c%0d", i), 0, 0, 0, 0, 1, 0);
    cyc("ill_c6", 0, 0, 0, 0, 0, 0);
    cyc("last_c0", 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc($sformatf("last_c%0d", i), 0, 0, 0, 0, 1, 0);
    cyc("last_c5", 0, 1, 1, 0, 1, 0);
    cyc("last_c6", 0, 0, 0, 0, 0, 0);
    cyc("last_c7", 0, 0, 0, 0, 0, 0);
    cyc("rdiv_c0", 0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cyc($sformatf("rdiv_c%0d", i), 0, 0, 0, 0, 1, 0);
    cyc("rdiv_c4_rst", 1, 0, 0, 0, 0, 0);
    cyc("rdiv_c5", 0, 0, 0, 0, 0, 0);
    cyc("rdiv_c6", 0, 0, 0, 0, 0, 0);
    step("br_stall", 0, 32'h3000, 1, 0, 0, 0, 1, 32'h3100, 32'h3100, 1, 0, 0);
    step("br_taken", 0, 32'h3000, 0, 0, 0, 0, 1, 32'h3200, 32'h3200, 0, 0, 0);
    step("wrap", 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
`ifdef FETCH_CTRL_ADEL_EN
    step("misalign", 0, 32'h3000, 0, 0, 0, 0, 1, 32'h3102, 32'h4180, 0, 0, 1);
`else
    step("misalign", 0, 32'h3000, 0, 0, 0, 0, 1, 32'h3102, 32'h3102, 0, 0, 0);
`endif
    step("idle", 0, 32'h3000, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameters: MULT_CYC, default 5, cycles a multiply occupies HI/LO; DIV_CYC, default 10, cycles a divide occupies HI/LO; RESET_PC, default 32'h0000_3000, boot address.
REQ-002 SHALL have ports, one per line as follows:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- PC_F  in  32  current fetch address from the PC register.
- hzd_stall  in  1  data-hazard stall request from the D-stage hazard unit.
- md_start  in  1  E-stage mult/div issue; one-cycle pulse.
- md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply.
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- br_taken_D  in  1  D-stage branch or jump resolved taken.
- br_target_D  in  32  D-stage branch or jump target.
- NPC_F  out  32  next fetch address to the PC register.
- stall  out  1  freezes the PC register and the F/D register.
- flush_E  out  1  inserts a bubble into the D/E register.
- md_busy  out  1  HI/LO unit occupied.
- exc_adel  out  1  misaligned-fetch flag (see REQ-016).

Function
REQ-003 SHALL compute NPC_F = br_target_D when br_taken_D, else PC_F + 4; addition modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-004 SHALL implement a two-state FSM: IDLE and MD_BUSY.
REQ-005 In IDLE with md_start = 1, the FSM SHALL go to MD_BUSY and load cnt with DIV_CYC-1 (md_is_div = 1) or MULT_CYC-1 (md_is_div = 0).
REQ-006 In MD_BUSY, cnt SHALL decrement each cycle; at cnt = 0 the FSM SHALL return to IDLE.
REQ-007 md_busy SHALL be 1 exactly while the FSM is in MD_BUSY; a multiply gives MULT_CYC busy cycles and a divide gives DIV_CYC busy cycles.
REQ-008 stall SHALL equal hzd_stall | (md_use_D & (md_busy | md_start)), combinationally.
REQ-009 flush_E SHALL equal stall.
REQ-010 md_start while in MD_BUSY is illegal, because REQ-008 prevents it; the block SHALL ignore it and leave cnt unchanged.
REQ-011 md_start in the same cycle that cnt = 0 in MD_BUSY (the final busy cycle) is also illegal; it SHALL be ignored and the FSM SHALL return to IDLE.
REQ-012 br_taken_D together with stall SHALL still drive NPC_F = br_target_D; the PC register does not load it because of the stall, and the branch re-resolves once the stall clears.
REQ-013 cnt SHALL be $clog2(DIV_CYC) bits wide (DIV_CYC >= MULT_CYC >= 1), and cnt SHALL never underflow.

Reset
REQ-014 While reset = 1, the block SHALL asynchronously force FSM = IDLE, cnt = 0, md_busy = 0 and exc_adel = 0; stall and flush_E then follow hzd_stall.
REQ-015 Reset during MD_BUSY SHALL abort the operation immediately; on the first cycle after release the FSM is in IDLE.

Configuration
REQ-016 With macro FETCH_CTRL_ADEL_EN defined, a taken branch whose br_target_D[1:0] != 0 SHALL drive NPC_F = 32'h0000_4180 and assert exc_adel for that cycle.
REQ-017 Without FETCH_CTRL_ADEL_EN, exc_adel SHALL be tied to 0 and targets SHALL pass through unchanged.

Structure
REQ-018 The shared package SHALL hold: FSM state typedef (IDLE, MD_BUSY); constants RESET_PC, EXC_VEC = 32'h0000_4180, PC_STEP = 4.
REQ-019 A sub-module md_busy_cnt (FSM plus cnt) is natural; NPC selection and stall logic SHALL stay in fetch_ctrl.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Sequential: PC_F = 32'h3000, no branch -> NPC_F = 32'h3004, stall = 0.
- Mult hazard: md_start, md_is_div = 0 in cycle 0, md_use_D = 1 -> stall = 1 in cycles 0-5 (md_start plus 5 busy cycles), 0 in cycle 6; md_busy high for exactly 5 cycles.
- Divide: md_start, md_is_div = 1 -> md_busy high for exactly 10 cycles; md_use_D = 0 -> stall stays 0 throughout.
- Mid-busy reset: reset asserted during divide busy cycle 4 -> md_busy = 0 at once, FSM in IDLE after release.
- Branch under stall: br_taken_D = 1, br_target_D = 32'h3100, hzd_stall = 1 -> NPC_F = 32'h3100, stall = 1, flush_E = 1.
- Wrap and misalignment: PC_F = 32'hFFFF_FFFC -> NPC_F = 0; with FETCH_CTRL_ADEL_EN, target 32'h3102 -> NPC_F = 32'h4180, exc_adel = 1.
